// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The queue entry carries a PC_W-wide PC, so fetch_unit's bus parameter must equal PC_W.
package fetch_pkg;

  localparam int unsigned PC_W           = 32;
  localparam logic [31:0] NOP_INSTR      = 32'h0;
  localparam int unsigned PC_STEP        = 4;
  localparam int unsigned QDEPTH_DEFAULT = 2;
  localparam int unsigned QIDX_W         = $clog2(QDEPTH_DEFAULT);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, decoder-facing outputs,
// redirect/stall controls and performance counters.
interface fetch_if #(
  parameter int unsigned bus = 32
);

  logic           imem_req;
  logic [bus-1:0] imem_addr;
  logic           imem_valid;
  logic [31:0]    imem_rdata;
  logic           stall;
  logic           branch_taken;
  logic [bus-1:0] branch_target;
  logic [31:0]    instruction;
  logic [bus-1:0] PCo;
  logic           valid;
  logic [31:0]    perf_fetched;
  logic [31:0]    perf_dropped;
  logic [31:0]    perf_stalls;

  modport master (
    output imem_req, imem_addr, instruction, PCo, valid,
           perf_fetched, perf_dropped, perf_stalls,
    input  imem_valid, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, PCo, valid,
           perf_fetched, perf_dropped, perf_stalls,
    output imem_valid, imem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t with push, pop, flush and occupancy count.
// Flush wins over push; DEPTH must be a power of two, at least 2.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = QDEPTH_DEFAULT,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_t     o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [IDX_W-1:0] r_rd;
  logic [IDX_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + IDX_W'(1);
      if (w_pop)  r_rd <= r_rd + IDX_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word reads and feeds the decoder.
// Optional counters are compiled in with `define FETCH_PERF_EN; otherwise they read as zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    bus      = PC_W,
  parameter logic [bus-1:0] RESET_PC = '0,
  parameter int unsigned    QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master fif
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [bus-1:0]   r_pc;
  logic [bus-1:0]   r_req_pc;
  logic             r_outstanding;
  logic             r_epoch;
  logic             r_req_epoch;
  logic             r_valid;
  logic [31:0]      r_instr;
  logic [bus-1:0]   r_pco;

  logic             w_issue;
  logic             w_resp;
  logic             w_push;
  logic             w_load;
  logic             w_pop;
  logic [SUM_W-1:0] w_inflight;
  fetch_entry_t     w_entry;
  fetch_entry_t     w_head;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;

  // Queued plus in-flight words never exceed QDEPTH, so a response always has a slot.
  assign w_inflight = SUM_W'(w_count) + SUM_W'(r_outstanding);
  assign w_issue    = !rst && !fif.branch_taken && (!r_outstanding || fif.imem_valid)
                      && (w_inflight < SUM_W'(QDEPTH));
  assign w_resp     = fif.imem_valid && r_outstanding;
  assign w_push     = w_resp && (r_req_epoch == r_epoch) && !fif.branch_taken;
  assign w_load     = !r_valid || !fif.stall;
  assign w_pop      = w_load && !w_empty && !fif.branch_taken;
  assign w_entry    = '{pc: r_req_pc, instr: fif.imem_rdata};

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .i_flush (fif.branch_taken),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_epoch       <= 1'b0;
      r_req_epoch   <= 1'b0;
      r_valid       <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_pco         <= '0;
    end else begin
      if (w_issue) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_pc;
        r_req_epoch   <= r_epoch;
        r_pc          <= r_pc + bus'(PC_STEP);
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end

      // A redirect leaves any outstanding request in flight but tags it stale via the epoch.
      if (fif.branch_taken) begin
        r_pc    <= fif.branch_target & ~bus'(3);
        r_epoch <= ~r_epoch;
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end else if (w_load) begin
        if (!w_empty) begin
          r_valid <= 1'b1;
          r_instr <= w_head.instr;
          r_pco   <= w_head.pc;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign fif.imem_req    = w_issue;
  assign fif.imem_addr   = r_pc;
  assign fif.instruction = r_instr;
  assign fif.PCo         = r_pco;
  assign fif.valid       = r_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_stalls;
  logic        w_resp_dropped;
  logic [31:0] w_flushed;

  assign w_resp_dropped = w_resp && !w_push;
  assign w_flushed      = fif.branch_taken ? 32'(w_count) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      r_perf_dropped <= r_perf_dropped + 32'(w_resp_dropped) + w_flushed;
      if (r_valid && fif.stall) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign fif.perf_fetched = r_perf_fetched;
  assign fif.perf_dropped = r_perf_dropped;
  assign fif.perf_stalls  = r_perf_stalls;
`else
  assign fif.perf_fetched = 32'd0;
  assign fif.perf_dropped = 32'd0;
  assign fif.perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model plus a scoreboard of expected PCs
// that is popped whenever the decoder side accepts an instruction (valid && !stall).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.bus(32)) fif ();
  fetch_if #(.bus(32)) wif ();

  fetch_unit #(.bus(32), .RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif.master)
  );

  fetch_unit #(.bus(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .fif (wif.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  mreq_t       mq_w[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_w[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  logic        req_seen;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'h2113_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: present due memory responses, record requests, score accepted outputs, clock.
  task automatic step();
    logic [31:0] e;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      fif.imem_valid = 1'b1;
      fif.imem_rdata = mem_data(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      fif.imem_valid = 1'b0;
      fif.imem_rdata = 32'hDEAD_BEEF;
    end
    if (mq_w.size() > 0 && mq_w[0].due <= cyc) begin
      wif.imem_valid = 1'b1;
      wif.imem_rdata = mem_data(mq_w[0].addr);
      void'(mq_w.pop_front());
    end else begin
      wif.imem_valid = 1'b0;
      wif.imem_rdata = 32'hDEAD_BEEF;
    end
    #1;
    req_seen = fif.imem_req;
    if (fif.imem_req) mq.push_back('{fif.imem_addr, cyc + mem_lat});
    if (wif.imem_req) mq_w.push_back('{wif.imem_addr, cyc + 1});
    if (dut.u_queue.i_push) check("push_on_full", 32'(dut.u_queue.o_full), 32'd0);
    if (fif.valid && !fif.stall && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pco", fif.PCo, e);
      check("sb_instr", fif.instruction, mem_data(e));
    end
    if (wif.valid && !wif.stall && exp_w.size() > 0) begin
      e = exp_w.pop_front();
      check("sbw_pco", wif.PCo, e);
      check("sbw_instr", wif.instruction, mem_data(e));
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fif.imem_valid = 1'b0; fif.imem_rdata = '0; fif.stall = 1'b0;
    fif.branch_taken = 1'b0; fif.branch_target = '0;
    wif.imem_valid = 1'b0; wif.imem_rdata = '0; wif.stall = 1'b0;
    wif.branch_taken = 1'b0; wif.branch_target = '0;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) step();

    // Reset state
    check("rst_req", 32'(fif.imem_req), 32'd0);
    check("rst_valid", 32'(fif.valid), 32'd0);
    check("rst_instr", fif.instruction, NOP_INSTR);
    check("rst_pco", fif.PCo, 32'h0);
    check("rst_addr", fif.imem_addr, 32'h0);
    check("rst_addr_w", wif.imem_addr, 32'hFFFF_FFF8);
    check("rst_perf_f", fif.perf_fetched, 32'd0);
    check("rst_perf_d", fif.perf_dropped, 32'd0);
    check("rst_perf_s", fif.perf_stalls, 32'd0);

    // 1: first valid three cycles after reset release, then in-order stream
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step(); check("t1_valid_c1", 32'(fif.valid), 32'd0);
    step(); check("t1_valid_c2", 32'(fif.valid), 32'd0);
    step(); check("t1_valid_c3", 32'(fif.valid), 32'd1);
    check("t1_first_pco", fif.PCo, 32'h0);
    for (int i = 0; i < 30 && !(fif.valid && fif.PCo == 32'h8); i++) step();
    check("t1_reach_8", 32'(fif.valid && fif.PCo == 32'h8), 32'd1);
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // 2: stall holds outputs, queue fills, issue stops, stream resumes without gap/duplicate
    fif.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", 32'(fif.valid), 32'd1);
      check("t2_hold_pco", fif.PCo, 32'h8);
      check("t2_hold_instr", fif.instruction, mem_data(32'h8));
    end
    check("t2_req_full", 32'(fif.imem_req), 32'd0);
`ifdef FETCH_PERF_EN
    check("t2_perf_stalls", fif.perf_stalls, 32'd5);
`else
    check("t2_perf_stalls", fif.perf_stalls, 32'd0);
`endif
    fif.stall = 1'b0;
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check("t2_sb_drained", 32'(exp_q.size()), 32'd0);

    // 3: redirect with a request outstanding; its late response must be dropped
    mem_lat = 2;
    for (int i = 0; i < 20 && !(mq.size() > 0 && mq[0].due > cyc); i++) step();
    check("t3_outstanding", 32'(mq.size() > 0 && mq[0].due > cyc), 32'd1);
    fif.branch_taken = 1'b1; fif.branch_target = 32'h40;
    exp_q.delete();
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    step();
    fif.branch_taken = 1'b0;
    check("t3_no_issue", 32'(req_seen), 32'd0);
    check("t3_valid", 32'(fif.valid), 32'd0);
    check("t3_instr_nop", fif.instruction, NOP_INSTR);
    check("t3_pc", fif.imem_addr, 32'h40);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    check("t3_perf_dropped", 32'(fif.perf_dropped >= 32'd1), 32'd1);
    check("t3_perf_fetched", 32'(fif.perf_fetched != 32'd0), 32'd1);
`else
    check("t3_perf_dropped", fif.perf_dropped, 32'd0);
    check("t3_perf_fetched", fif.perf_fetched, 32'd0);
`endif
    mem_lat = 1;

    // 4: redirect and stall together, misaligned target; redirect wins
    for (int i = 0; i < 20 && !fif.valid; i++) step();
    check("t4_valid_before", 32'(fif.valid), 32'd1);
    fif.stall = 1'b1; fif.branch_taken = 1'b1; fif.branch_target = 32'h83;
    exp_q.delete();
    exp_q.push_back(32'h80); exp_q.push_back(32'h84); exp_q.push_back(32'h88);
    step();
    fif.stall = 1'b0; fif.branch_taken = 1'b0;
    check("t4_no_issue", 32'(req_seen), 32'd0);
    check("t4_valid", 32'(fif.valid), 32'd0);
    check("t4_instr_nop", fif.instruction, NOP_INSTR);
    check("t4_pc_aligned", fif.imem_addr, 32'h80);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // 5 and 6: reset with a response arriving that cycle; both instances restart
    for (int i = 0; i < 20 && !(mq.size() > 0 && mq[0].due <= cyc); i++) step();
    check("t5_resp_now", 32'(mq.size() > 0 && mq[0].due <= cyc), 32'd1);
    rst = 1'b1;
    exp_q.delete(); exp_w.delete();
    step();
    check("t5_req_in_rst", 32'(req_seen), 32'd0);
    check("t5_valid", 32'(fif.valid), 32'd0);
    check("t5_instr", fif.instruction, NOP_INSTR);
    check("t5_pco", fif.PCo, 32'h0);
    check("t5_addr", fif.imem_addr, 32'h0);
    check("t5_perf_f", fif.perf_fetched, 32'd0);
    check("t5_perf_d", fif.perf_dropped, 32'd0);
    check("t5_perf_s", fif.perf_stalls, 32'd0);
    check("t6_pco_w", wif.PCo, 32'h0);
    check("t6_addr_w", wif.imem_addr, 32'hFFFF_FFF8);
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_w.push_back(32'hFFFF_FFF8); exp_w.push_back(32'hFFFF_FFFC);
    exp_w.push_back(32'h0); exp_w.push_back(32'h4);
    for (int i = 0; i < 40 && (exp_q.size() > 0 || exp_w.size() > 0); i++) step();
    check("t5_sb_drained", 32'(exp_q.size()), 32'd0);
    check("t6_sb_drained", 32'(exp_w.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
